// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences one word access at a time between the processor control FSM and a
//   byte-addressed, level-sensitive unified instruction/data memory. A request
//   is bounds/alignment checked, the address is presented for one strobe-free
//   settle cycle, then exactly one strobe is held for WAIT_CYCLES cycles. Read
//   data is captured into the Instruction Register or Memory Data Register.
//   Faulting requests never reach the memory.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake (ready only when idle)
//   req_we             1 = store word, 0 = read word
//   req_is_instr       read target: 1 = IR, 0 = MDR
//   req_addr/wdata     byte address and store data
//   rsp_valid/err      one-cycle completion pulse, err marks a faulted access
//   ir_out, mdr_out    Instruction Register, Memory Data Register
//   mem_read/write     memory strobes (never both high)
//   mem_addr/wdata     memory address and write data
//   mem_rdata          combinational memory read data
module mem_access_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_BYTES   = 1096,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_is_instr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ERR,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    // Highest legal word address, one bit wider than the address so that
    // addresses close to 2^ADDR_W cannot wrap into range.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(MEM_BYTES - 4);
    localparam logic [3:0]      CNT_LOAD  = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic                is_instr_q, is_instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                fault;

    assign fault = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} > LAST_WORD);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        is_instr_d  = is_instr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                // ready_q is still 0 on the first cycle out of reset, so no
                // request can be taken before req_ready is visible.
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    we_d       = req_we;
                    is_instr_d = req_is_instr;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    ready_d    = 1'b0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (fault) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                mem_read_d  = !we_q;
                mem_write_d = we_q;
                cnt_d       = CNT_LOAD;
                state_d     = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (is_instr_q) begin
                            ir_d = mem_rdata;
                        end else begin
                            mdr_d = mem_rdata;
                        end
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                    mem_read_d  = !we_q;
                    mem_write_d = we_q;
                end
            end
            S_DONE, S_ERR: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            is_instr_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ir_q        <= '0;
            mdr_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            is_instr_q  <= is_instr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign ir_out    = ir_q;
    assign mdr_out   = mdr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 1 and 3), each with
// its own byte-array memory, checked against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int unsigned MEM_BYTES = 1096;
    localparam int unsigned W0 = 1;
    localparam int unsigned W1 = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic        req_is_instr [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_err [2];
    logic [31:0] ir_out [2];
    logic [31:0] mdr_out [2];
    logic        mem_read [2];
    logic        mem_write [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    logic [7:0]  mem [2][MEM_BYTES];
    logic [7:0]  ref_mem [2][MEM_BYTES];
    logic [31:0] m_ir [2];
    logic [31:0] m_mdr [2];

    int unsigned nvec = 0;
    int unsigned nmis = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc;
    int          cur_k;
    logic        hold_we, hold_ii;
    logic [31:0] hold_addr, hold_wdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEM_BYTES), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_is_instr(req_is_instr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .ir_out(ir_out[0]), .mdr_out(mdr_out[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEM_BYTES), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_is_instr(req_is_instr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .ir_out(ir_out[1]), .mdr_out(mdr_out[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Big-endian level-sensitive memory: combinational read, write while strobed.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            int unsigned a;
            a = mem_addr[k];
            if (a <= MEM_BYTES - 4)
                mem_rdata[k] = {mem[k][a], mem[k][a+1], mem[k][a+2], mem[k][a+3]};
            else
                mem_rdata[k] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int unsigned a;
            a = mem_addr[k];
            if (mem_write[k] && a <= MEM_BYTES - 4) begin
                mem[k][a]   = mem_wdata[k][31:24];
                mem[k][a+1] = mem_wdata[k][23:16];
                mem[k][a+2] = mem_wdata[k][15:8];
                mem[k][a+3] = mem_wdata[k][7:0];
            end
        end
    end

    function automatic logic [7:0] init_byte(int unsigned a);
        int unsigned v;
        case (a)
            0: return 8'h8C;
            1: return 8'h64;
            2: return 8'h00;
            3: return 8'h64;
            default: begin
                v = a * 7 + 3;
                return v[7:0];
            end
        endcase
    endfunction

    function automatic int unsigned wait_of(int k);
        return (k == 0) ? W0 : W1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h (t=%0t)", name, cur_k, act, exp, $time);
        end
    endtask

    // Starts and ends just after a falling edge.
    task automatic do_req(int k, logic we, logic ii, logic [31:0] addr, logic [31:0] wdata,
                          logic hold, output logic got_err);
        int unsigned n, lat, rd, wr, first, w;
        logic ovl, abad, wdbad, rdy_busy, bad, done;
        logic [31:0] word;
        cur_k = k;
        got_err = 1'b0;
        req_we[k] = we; req_is_instr[k] = ii; req_addr[k] = addr; req_wdata[k] = wdata;
        req_valid[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
        if (!req_ready[k]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk); #1 acc_cyc = cyc;
        @(negedge clk);
        if (hold) begin
            req_we[k] = hold_we; req_is_instr[k] = hold_ii;
            req_addr[k] = hold_addr; req_wdata[k] = hold_wdata;
        end else begin
            req_valid[k] = 1'b0;
        end
        w = wait_of(k);
        bad = (addr[1:0] != 2'b00) || (longint'(addr) + 3 >= longint'(MEM_BYTES));
        rd = 0; wr = 0; first = 0; lat = 0;
        ovl = 0; abad = 0; wdbad = 0; rdy_busy = 0; done = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            if (mem_read[k]) rd++;
            if (mem_write[k]) wr++;
            if (mem_read[k] && mem_write[k]) ovl = 1;
            if ((mem_read[k] || mem_write[k]) && first == 0) first = c;
            if ((mem_read[k] || mem_write[k]) && mem_addr[k] !== addr) abad = 1;
            if (mem_write[k] && mem_wdata[k] !== wdata) wdbad = 1;
            if (req_ready[k]) rdy_busy = 1;
            if (rsp_valid[k]) begin
                lat = c; got_err = rsp_err[k]; done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        // Transaction-level model update.
        if (!bad) begin
            if (we) begin
                ref_mem[k][addr]   = wdata[31:24];
                ref_mem[k][addr+1] = wdata[23:16];
                ref_mem[k][addr+2] = wdata[15:8];
                ref_mem[k][addr+3] = wdata[7:0];
            end else begin
                word = {ref_mem[k][addr], ref_mem[k][addr+1], ref_mem[k][addr+2], ref_mem[k][addr+3]};
                if (ii) m_ir[k] = word; else m_mdr[k] = word;
            end
        end
        chk("rsp_err", {31'd0, got_err}, {31'd0, bad});
        chk("latency", lat, bad ? 32'd2 : 32'(3 + w));
        chk("read_strobe_cycles", rd, (!bad && !we) ? w : 0);
        chk("write_strobe_cycles", wr, (!bad && we) ? w : 0);
        chk("first_strobe_cycle", first, bad ? 32'd0 : 32'd3);
        chk("strobe_overlap", {31'd0, ovl}, 32'd0);
        chk("strobe_addr", {31'd0, abad}, 32'd0);
        chk("strobe_wdata", {31'd0, wdbad}, 32'd0);
        chk("ready_while_busy", {31'd0, rdy_busy}, 32'd0);
        chk("ir_out", ir_out[k], m_ir[k]);
        chk("mdr_out", mdr_out[k], m_mdr[k]);
        @(negedge clk);
        chk("rsp_pulse_width", {31'd0, rsp_valid[k]}, 32'd0);
        chk("ready_after_done", {31'd0, req_ready[k]}, 32'd1);
    endtask

    task automatic chk_all_zero(int k);
        cur_k = k;
        chk("rst_req_ready", {31'd0, req_ready[k]}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err[k]}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read[k]}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write[k]}, 32'd0);
        chk("rst_mem_addr", mem_addr[k], 32'd0);
        chk("rst_mem_wdata", mem_wdata[k], 32'd0);
        chk("rst_ir_out", ir_out[k], 32'd0);
        chk("rst_mdr_out", mdr_out[k], 32'd0);
    endtask

    task automatic release_reset(int k);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cur_k = k;
        chk("ready_before_edge", {31'd0, req_ready[k]}, 32'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", {31'd0, req_ready[k]}, 32'd1);
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle during the first ACCESS cycle of a request.
    task automatic rst_mid(int k, logic we, logic [31:0] addr, logic [31:0] wdata);
        logic seen;
        cur_k = k;
        req_we[k] = we; req_is_instr[k] = 1'b0; req_addr[k] = addr; req_wdata[k] = wdata;
        req_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk); req_valid[k] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("strobe_before_reset", {31'd0, we ? mem_write[k] : mem_read[k]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero(k);
        for (int j = 0; j < 2; j++) begin m_ir[j] = '0; m_mdr[j] = '0; end
        repeat (2) @(negedge clk);
        release_reset(k);
        seen = 0;
        repeat (6) begin
            if (rsp_valid[k]) seen = 1;
            @(negedge clk);
        end
        chk("no_rsp_after_abort", {31'd0, seen}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic        ii;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic e;
        int unsigned a1;
        tbl[0] = '{1'b0, 1'b1, 32'd0,          32'd0,          1'b0, 1'b1, 32'h8C640064};
        tbl[1] = '{1'b1, 1'b0, 32'd108,        32'h0000001E,   1'b0, 1'b0, 32'd0};
        tbl[2] = '{1'b0, 1'b0, 32'd108,        32'd0,          1'b0, 1'b1, 32'h0000001E};
        tbl[3] = '{1'b0, 1'b0, 32'h66,         32'd0,          1'b1, 1'b0, 32'd0};
        tbl[4] = '{1'b1, 1'b0, 32'd1092,       32'hCAFEF00D,   1'b0, 1'b0, 32'd0};
        tbl[5] = '{1'b0, 1'b0, 32'd1092,       32'd0,          1'b0, 1'b1, 32'hCAFEF00D};
        tbl[6] = '{1'b0, 1'b0, 32'd1096,       32'd0,          1'b1, 1'b0, 32'd0};
        tbl[7] = '{1'b0, 1'b0, 32'hFFFFFFFC,   32'd0,          1'b1, 1'b0, 32'd0};
        tbl[8] = '{1'b0, 1'b1, 32'd1092,       32'd0,          1'b0, 1'b1, 32'hCAFEF00D};

        for (int k = 0; k < 2; k++) begin
            for (int unsigned a = 0; a < MEM_BYTES; a++) begin
                mem[k][a] = init_byte(a);
                ref_mem[k][a] = init_byte(a);
            end
            m_ir[k] = '0; m_mdr[k] = '0;
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_is_instr[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0;
        end

        repeat (3) @(negedge clk);
        chk_all_zero(0);
        chk_all_zero(1);
        release_reset(0);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) begin
                do_req(k, tbl[i].we, tbl[i].ii, tbl[i].addr, tbl[i].wdata, 1'b0, e);
                cur_k = k;
                chk("tbl_err", {31'd0, e}, {31'd0, tbl[i].exp_err});
                if (tbl[i].chk_data)
                    chk("tbl_data", tbl[i].ii ? ir_out[k] : mdr_out[k], tbl[i].exp_data);
            end
        end

        // Requester holds req_valid across two back-to-back stores.
        for (int k = 0; k < 2; k++) begin
            hold_we = 1'b1; hold_ii = 1'b0; hold_addr = 32'd200; hold_wdata = 32'h12345678;
            do_req(k, 1'b1, 1'b0, 32'd196, 32'hAAAA5555, 1'b1, e);
            a1 = acc_cyc;
            do_req(k, 1'b1, 1'b0, 32'd200, 32'h12345678, 1'b0, e);
            cur_k = k;
            chk("hold_accept_gap", acc_cyc - a1, 32'(4 + wait_of(k)));
            do_req(k, 1'b0, 1'b0, 32'd196, 32'd0, 1'b0, e);
            do_req(k, 1'b0, 1'b1, 32'd200, 32'd0, 1'b0, e);
        end

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 50; i++) begin
                int unsigned sel;
                logic [31:0] addr;
                sel = $urandom_range(0, 9);
                if (sel < 7)       addr = $urandom_range(0, 273) * 4;
                else if (sel == 7) addr = $urandom_range(0, 273) * 4 + $urandom_range(1, 3);
                else if (sel == 8) addr = $urandom_range(274, 2000) * 4;
                else               addr = 32'hFFFFFFFC - $urandom_range(0, 3) * 4;
                do_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom, 1'b0, e);
            end
        end

        rst_mid(0, 1'b1, 32'd300, 32'hDEADBEEF);
        rst_mid(1, 1'b0, 32'd0, 32'd0);
        do_req(1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, e);
        do_req(0, 1'b0, 1'b0, 32'd1092, 32'd0, 1'b0, e);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
